// File: rtl/wm_pkg.sv
// Shared definitions for the wash sequencer: state codes, step indices, program word layout.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package wm_pkg;

   // Sequencer state codes
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Step indices in execution order
   localparam logic [2:0] STEP_FILL1  = 3'd0;
   localparam logic [2:0] STEP_WASH   = 3'd1;
   localparam logic [2:0] STEP_DRAIN1 = 3'd2;
   localparam logic [2:0] STEP_SPIN1  = 3'd3;
   localparam logic [2:0] STEP_FILL2  = 3'd4;
   localparam logic [2:0] STEP_RINSE  = 3'd5;
   localparam logic [2:0] STEP_DRAIN2 = 3'd6;
   localparam logic [2:0] STEP_SPIN2  = 3'd7;

   // Bit position of each step's duration field inside the 26-bit program word
   localparam int FIELD_MSB [8] = '{25, 22, 18, 15, 12, 9, 5, 2};
   localparam int FIELD_LSB [8] = '{23, 19, 16, 13, 10, 6, 3, 0};

   // Duration of step idx, zero-extended to 4 bits (3-bit fields get a 0 MSB)
   function automatic logic [3:0] field_of(input logic [25:0] p, input logic [2:0] idx);
      logic [3:0] mask;
      mask = ((FIELD_MSB[idx] - FIELD_LSB[idx]) == 3) ? 4'hF : 4'h7;
      return 4'(p >> FIELD_LSB[idx]) & mask;
   endfunction

   // Whole-program duration; at most 6*7 + 2*15 = 72, fits in 7 bits
   function automatic logic [6:0] total_of(input logic [25:0] p);
      logic [6:0] sum;
      sum = '0;
      for (int i = 0; i < 8; i++) begin
         sum = sum + {3'b000, field_of(p, 3'(i))};
      end
      return sum;
   endfunction

endpackage

// File: rtl/wash_sequencer_next_step_finder.sv
// Finds the lowest-numbered step after idx (or from step 0 when none is set) with a nonzero duration.
// Latency: purely combinational.
// Backpressure: none.
import wm_pkg::*;

module next_step_finder (
   input  logic [25:0] prog,
   input  logic [2:0]  idx,
   input  logic        none,
   output logic        found,
   output logic [2:0]  next_idx,
   output logic [3:0]  dur
);

   // Scan downwards so the lowest qualifying index is the last one written
   always_comb begin
      found    = 1'b0;
      next_idx = '0;
      dur      = '0;
      for (int i = 7; i >= 0; i--) begin
         if ((none || (3'(i) > idx)) && (field_of(prog, 3'(i)) != 4'd0)) begin
            found    = 1'b1;
            next_idx = 3'(i);
            dur      = field_of(prog, 3'(i));
         end
      end
   end

endmodule

// File: rtl/wash_sequencer.sv
// Runs the snapshotted 8-step wash program, counting each step down on the 1 Hz tick.
// Latency: every output is registered; a start/tick/pause/abort shows up on the outputs one cp later.
// Backpressure: none; tick/pause/abort are sampled every cycle, priority abort > pause > tick.
import wm_pkg::*;

module wash_sequencer #(
   parameter int DONE_TICKS = 3
) (
   input  logic        cp,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        start,
   input  logic        pause,
   input  logic        abort,
   input  logic [25:0] prog,
   output logic        busy,
   output logic [2:0]  step_idx,
   output logic [3:0]  step_left,
   output logic [6:0]  total_left,
   output logic        water_valve,
   output logic        motor_wash,
   output logic        drain_valve,
   output logic        motor_spin,
   output logic        buzzer
);

   logic [1:0]  state, state_n;
   logic [25:0] snap, snap_n;
   logic [2:0]  idx_n;
   logic [3:0]  left_n;
   logic [6:0]  total_n;
   logic [3:0]  done_cnt, cnt_n;

   logic        in_idle;
   logic [25:0] finder_prog;
   logic        f_found;
   logic [2:0]  f_idx;
   logic [3:0]  f_dur;
   logic        run_n;

   // In IDLE the finder looks at the live word to pick the first step; afterwards at the snapshot
   assign in_idle     = (state == ST_IDLE);
   assign finder_prog = in_idle ? prog : snap;
   assign run_n       = (state_n == ST_RUN);

   next_step_finder u_finder (
      .prog     (finder_prog),
      .idx      (step_idx),
      .none     (in_idle),
      .found    (f_found),
      .next_idx (f_idx),
      .dur      (f_dur)
   );

   // Next-state and counter update
   always_comb begin
      state_n = state;
      snap_n  = snap;
      idx_n   = step_idx;
      left_n  = step_left;
      total_n = total_left;
      cnt_n   = done_cnt;
      if (abort) begin
         state_n = ST_IDLE;
         idx_n   = '0;
         left_n  = '0;
         total_n = '0;
         cnt_n   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  snap_n = prog;
                  cnt_n  = '0;
                  if (f_found) begin
                     state_n = ST_RUN;
                     idx_n   = f_idx;
                     left_n  = f_dur;
                     total_n = total_of(prog);
                  end else begin
                     state_n = ST_DONE;
                     idx_n   = '0;
                     left_n  = '0;
                     total_n = '0;
                  end
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_n = ST_PAUSE;
               end else if (tick) begin
                  total_n = total_left - 7'd1;
                  if (step_left <= 4'd1) begin
                     if (f_found) begin
                        idx_n  = f_idx;
                        left_n = f_dur;
                     end else begin
                        state_n = ST_DONE;
                        left_n  = '0;
                        total_n = '0;
                        cnt_n   = '0;
                     end
                  end else begin
                     left_n = step_left - 4'd1;
                  end
               end
            end
            ST_PAUSE: begin
               if (!pause) state_n = ST_RUN;
            end
            ST_DONE: begin
               if (tick) begin
                  if (done_cnt == 4'(DONE_TICKS - 1)) begin
                     state_n = ST_IDLE;
                     idx_n   = '0;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = done_cnt + 4'd1;
                  end
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // State registers; actuators decoded from the next step so they line up with step_idx
   always_ff @(posedge cp or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         snap        <= '0;
         step_idx    <= '0;
         step_left   <= '0;
         total_left  <= '0;
         done_cnt    <= '0;
         busy        <= 1'b0;
         water_valve <= 1'b0;
         motor_wash  <= 1'b0;
         drain_valve <= 1'b0;
         motor_spin  <= 1'b0;
         buzzer      <= 1'b0;
      end else begin
         state       <= state_n;
         snap        <= snap_n;
         step_idx    <= idx_n;
         step_left   <= left_n;
         total_left  <= total_n;
         done_cnt    <= cnt_n;
         busy        <= run_n || (state_n == ST_PAUSE);
         water_valve <= run_n && ((idx_n == STEP_FILL1) || (idx_n == STEP_FILL2));
         motor_wash  <= run_n && ((idx_n == STEP_WASH) || (idx_n == STEP_RINSE));
         drain_valve <= run_n && ((idx_n == STEP_DRAIN1) || (idx_n == STEP_SPIN1) ||
                                  (idx_n == STEP_DRAIN2) || (idx_n == STEP_SPIN2));
         motor_spin  <= run_n && ((idx_n == STEP_SPIN1) || (idx_n == STEP_SPIN2));
         buzzer      <= (state_n == ST_DONE);
      end
   end

endmodule
